// File: rtl/aes_op_arb_pkg.sv
// Shared types and constants for the AES op-buffer arbiter.
package aes_op_arb_pkg;

  localparam int unsigned STAT_W   = 16;
  localparam int unsigned BLK_ROWS = 4;
  localparam int unsigned BLK_COLS = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  typedef logic [7:0] cipher_blk_t [BLK_ROWS][BLK_COLS];

endpackage

// File: rtl/aes_op_buf_arbiter_rr_pick.sv
// Round-robin selector: lowest-distance requester at or after ptr_i, wrapping at N-1.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  localparam int unsigned PW = IW + 1;
  localparam logic [PW-1:0] N_W = PW'(N);

  logic [PW-1:0] pos;

  // Scan farthest-first so the nearest requester overwrites the result last.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    pos     = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      pos = {1'b0, ptr_i} + PW'(k);
      if (pos >= N_W) begin
        pos = pos - N_W;
      end
      if (req_i[pos[IW-1:0]]) begin
        idx_o   = pos[IW-1:0];
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_op_buf_arbiter.sv
// Round-robin burst arbiter sharing one op-buffer port between AES cores.
// Optional per-core block / stall counters under AES_OP_ARB_STATS_EN.
module aes_op_buf_arbiter
  import aes_op_arb_pkg::*;
#(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned NO_ROWS   = 4,
  parameter int unsigned NO_COLS   = 4,
  parameter int unsigned IW        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                 aes_clk,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] core_txt_vld,
  output logic [NUM_CORES-1:0] core_txt_rdy,
  input  logic [7:0]           core_cipher_txt [NUM_CORES-1:0][NO_ROWS-1:0][NO_COLS-1:0],
  output logic                 cipher_txt_vld,
  input  logic                 cipher_txt_rdy,
  output logic [7:0]           p_cipher_txt [NO_ROWS-1:0][NO_COLS-1:0],
  output logic [IW-1:0]        cipher_src_id,
  output logic                 arb_busy
`ifdef AES_OP_ARB_STATS_EN
  ,
  output logic [NUM_CORES-1:0][STAT_W-1:0] blk_cnt,
  output logic [STAT_W-1:0]                stall_cnt
`endif
);

  localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] LAST_CORE = IW'(NUM_CORES - 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BW-1:0] beat_q, beat_d;

  logic          vld_q;
  logic [IW-1:0] src_q;
  logic [7:0]    blk_q [NO_ROWS-1:0][NO_COLS-1:0];

  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic          out_free;
  logic          xfer;

  rr_pick #(
    .N  (NUM_CORES),
    .IW (IW)
  ) u_rr_pick (
    .req_i   (core_txt_vld),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Output stage can take a new block when empty or draining this cycle.
  assign out_free = !vld_q || cipher_txt_rdy;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    beat_d       = beat_q;
    core_txt_rdy = '0;
    xfer         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          beat_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        core_txt_rdy[grant_q] = out_free;
        xfer = core_txt_vld[grant_q] && out_free;
        if ((xfer && (beat_q == LAST_BEAT)) || !core_txt_vld[grant_q]) begin
          state_d  = IDLE;
          beat_d   = '0;
          rr_ptr_d = (grant_q == LAST_CORE) ? '0 : grant_q + IW'(1);
        end else if (xfer) begin
          beat_d = beat_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aes_clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
    end
  end

  // Output register runs independently of the FSM; data holds while stalled.
  always_ff @(posedge aes_clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      src_q <= '0;
      blk_q <= '{default: '0};
    end else if (xfer) begin
      vld_q <= 1'b1;
      src_q <= grant_q;
      blk_q <= core_cipher_txt[grant_q];
    end else if (cipher_txt_rdy) begin
      vld_q <= 1'b0;
    end
  end

  assign cipher_txt_vld = vld_q;
  assign cipher_src_id  = src_q;
  assign p_cipher_txt   = blk_q;
  assign arb_busy       = (state_q != IDLE);

`ifdef AES_OP_ARB_STATS_EN
  logic [NUM_CORES-1:0][STAT_W-1:0] blk_cnt_q;
  logic [STAT_W-1:0]                stall_cnt_q;

  // Saturating activity counters.
  always_ff @(posedge aes_clk) begin
    if (reset) begin
      blk_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (xfer && (blk_cnt_q[grant_q] != '1)) begin
        blk_cnt_q[grant_q] <= blk_cnt_q[grant_q] + STAT_W'(1);
      end
      if (vld_q && !cipher_txt_rdy && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + STAT_W'(1);
      end
    end
  end

  assign blk_cnt   = blk_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_aes_op_buf_arbiter.sv
// Scoreboard bench for aes_op_buf_arbiter: directed core traffic, monitor-side compare.
module tb_aes_op_buf_arbiter;

  localparam int unsigned NC = 4;

  logic          aes_clk;
  logic          reset;
  logic [NC-1:0] core_txt_vld;
  logic [NC-1:0] core_txt_rdy;
  logic [7:0]    core_cipher_txt [NC-1:0][3:0][3:0];
  logic          cipher_txt_vld;
  logic          cipher_txt_rdy;
  logic [7:0]    p_cipher_txt [3:0][3:0];
  logic [1:0]    cipher_src_id;
  logic          arb_busy;
`ifdef AES_OP_ARB_STATS_EN
  logic [NC-1:0][15:0] blk_cnt;
  logic [15:0]         stall_cnt;
`endif

  aes_op_buf_arbiter #(
    .NUM_CORES (NC),
    .MAX_BURST (4),
    .NO_ROWS   (4),
    .NO_COLS   (4)
  ) dut (
    .aes_clk         (aes_clk),
    .reset           (reset),
    .core_txt_vld    (core_txt_vld),
    .core_txt_rdy    (core_txt_rdy),
    .core_cipher_txt (core_cipher_txt),
    .cipher_txt_vld  (cipher_txt_vld),
    .cipher_txt_rdy  (cipher_txt_rdy),
    .p_cipher_txt    (p_cipher_txt),
    .cipher_src_id   (cipher_src_id),
    .arb_busy        (arb_busy)
`ifdef AES_OP_ARB_STATS_EN
    ,
    .blk_cnt         (blk_cnt),
    .stall_cnt       (stall_cnt)
`endif
  );

  typedef struct packed {
    logic [1:0]   src;
    logic [127:0] data;
  } exp_t;

  exp_t         exp_q [$];
  logic [127:0] core_q [NC][$];
  int           xfer_cyc [$];

  logic [NC-1:0] en;
  logic          buf_rdy;
  logic          rst_req;
  int            vectors;
  int            miscompares;
  int            cyc;

  initial aes_clk = 1'b0;
  always #5 aes_clk = ~aes_clk;

  function automatic logic [127:0] mk_blk(int c, int b);
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[7'(k*8) +: 8] = 8'(k*16 + c*4 + b);
    v[7:0]  = 8'(c);
    v[15:8] = 8'(b);
    return v;
  endfunction

  function automatic logic [127:0] flat_out();
    logic [127:0] v;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        v[7'((r*4+c)*8) +: 8] = p_cipher_txt[r][c];
    return v;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(int c, logic [127:0] d, bit expect_out);
    exp_t e;
    core_q[c].push_back(d);
    if (expect_out) begin
      e.src  = 2'(c);
      e.data = d;
      exp_q.push_back(e);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge aes_clk);
    #1;
  endtask

  function automatic bit all_idle();
    bit idle;
    idle = (exp_q.size() == 0) && !cipher_txt_vld;
    for (int c = 0; c < NC; c++) if (core_q[c].size() != 0) idle = 1'b0;
    return idle;
  endfunction

  task automatic wait_drain(string name);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      step(1);
      done = all_idle();
    end
    check(name, 128'(done), 128'(1));
  endtask

  task automatic wait_out_vld(string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      step(1);
      seen = cipher_txt_vld;
    end
    check(name, 128'(seen), 128'(1));
  endtask

  task automatic do_reset();
    for (int c = 0; c < NC; c++) core_q[c].delete();
    exp_q.delete();
    en      = '1;
    buf_rdy = 1'b1;
    rst_req = 1'b1;
    step(3);
    rst_req = 1'b0;
    step(2);
  endtask

  // Driver: apply inputs on the falling edge, retire accepted core blocks just before the rising edge.
  initial begin
    rst_req = 1'b1;
    buf_rdy = 1'b1;
    en      = '1;
    reset   = 1'b1;
    cipher_txt_rdy = 1'b0;
    core_txt_vld   = '0;
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++) core_cipher_txt[c][r][k] = 8'h00;
    forever begin
      @(negedge aes_clk);
      reset          = rst_req;
      cipher_txt_rdy = buf_rdy;
      for (int c = 0; c < NC; c++) begin
        logic [127:0] head;
        head = (core_q[c].size() > 0) ? core_q[c][0] : 128'h0;
        core_txt_vld[c] = en[c] && (core_q[c].size() > 0);
        for (int r = 0; r < 4; r++)
          for (int k = 0; k < 4; k++) core_cipher_txt[c][r][k] = head[7'((r*4+k)*8) +: 8];
      end
      #4;
      for (int c = 0; c < NC; c++)
        if (core_txt_vld[c] && core_txt_rdy[c]) void'(core_q[c].pop_front());
    end
  end

  // Monitor: every buffer-side transfer is checked against the scoreboard head.
  initial begin
    exp_t e;
    cyc = 0;
    forever begin
      @(negedge aes_clk);
      #4;
      cyc++;
      if (!reset && cipher_txt_vld && cipher_txt_rdy) begin
        xfer_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_unexpected: got block from src %0d, expected none", cipher_src_id);
        end else begin
          e = exp_q.pop_front();
          check("sb_src", 128'(cipher_src_id), 128'(e.src));
          check("sb_data", flat_out(), e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ramp;
    vectors     = 0;
    miscompares = 0;
    for (int k = 0; k < 16; k++) ramp[7'(k*8) +: 8] = 8'(k);

    // Reset state
    step(3);
    check("rst_vld", 128'(cipher_txt_vld), 128'(0));
    check("rst_core_rdy", 128'(core_txt_rdy), 128'(0));
    check("rst_busy", 128'(arb_busy), 128'(0));
    check("rst_src", 128'(cipher_src_id), 128'(0));
    check("rst_data", flat_out(), 128'(0));
    rst_req = 1'b0;
    step(2);

    // Single core latency: vld at cycle 0, rdy at cycle 1, output at cycle 2
    push(2, ramp, 1'b1);
    @(negedge aes_clk); #1;
    check("t1_rdy_c0", 128'(core_txt_rdy), 128'(0));
    check("t1_busy_c0", 128'(arb_busy), 128'(0));
    @(negedge aes_clk); #1;
    check("t1_rdy_c1", 128'(core_txt_rdy), 128'(4'b0100));
    check("t1_busy_c1", 128'(arb_busy), 128'(1));
    check("t1_vld_c1", 128'(cipher_txt_vld), 128'(0));
    @(negedge aes_clk); #1;
    check("t1_vld_c2", 128'(cipher_txt_vld), 128'(1));
    check("t1_src_c2", 128'(cipher_src_id), 128'(2));
    check("t1_data_c2", flat_out(), ramp);
    wait_drain("t1_drain");

    // All cores busy: bursts of 4, one bubble between bursts, pointer wraps to core 0
    do_reset();
    for (int c = 0; c < NC; c++)
      for (int b = 0; b < 4; b++) push(c, mk_blk(c, b), 1'b1);
    push(0, mk_blk(0, 4), 1'b1);
    xfer_cyc.delete();
    wait_drain("t2_drain");
    check("t2_count", 128'(xfer_cyc.size()), 128'(17));
    if (xfer_cyc.size() == 17) check("t2_span", 128'(xfer_cyc[16] - xfer_cyc[0]), 128'(20));

    // Backpressure mid-burst: output and grant hold, no loss or duplication
    do_reset();
    for (int b = 0; b < 4; b++) push(1, mk_blk(1, b), 1'b1);
    wait_out_vld("t3_first_out");
    buf_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("t3_hold_data", flat_out(), mk_blk(1, 0));
      check("t3_hold_src", 128'(cipher_src_id), 128'(1));
      check("t3_hold_vld", 128'(cipher_txt_vld), 128'(1));
      check("t3_core_rdy", 128'(core_txt_rdy), 128'(0));
      check("t3_busy", 128'(arb_busy), 128'(1));
    end
    buf_rdy = 1'b1;
    wait_drain("t3_drain");
`ifdef AES_OP_ARB_STATS_EN
    check("t3_blk_cnt1", 128'(blk_cnt[1]), 128'(4));
    check("t3_blk_cnt0", 128'(blk_cnt[0]), 128'(0));
    check("t3_stall_cnt", 128'(stall_cnt), 128'(5));
`endif

    // Early release: core 1 stops after 2 blocks; core 2 wins over newly valid core 0
    do_reset();
    en = 4'b1110;
    push(1, mk_blk(1, 0), 1'b1);
    push(1, mk_blk(1, 1), 1'b1);
    push(2, mk_blk(2, 0), 1'b1);
    push(0, mk_blk(0, 0), 1'b1);
    wait_out_vld("t4_first_out");
    en = 4'b1111;
    wait_drain("t4_drain");

    // Reset while a stalled block is held: block discarded, pointer back to core 0
    do_reset();
    push(1, mk_blk(1, 5), 1'b1);
    wait_drain("t5_pre_drain");
    buf_rdy = 1'b0;
    push(3, mk_blk(3, 0), 1'b0);
    push(3, mk_blk(3, 1), 1'b0);
    wait_out_vld("t5_held");
    check("t5_held_src", 128'(cipher_src_id), 128'(3));
    for (int c = 0; c < NC; c++) core_q[c].delete();
    rst_req = 1'b1;
    step(1);
    check("t5_rst_vld", 128'(cipher_txt_vld), 128'(0));
    check("t5_rst_busy", 128'(arb_busy), 128'(0));
    check("t5_rst_core_rdy", 128'(core_txt_rdy), 128'(0));
    step(2);
    rst_req = 1'b0;
    buf_rdy = 1'b1;
    step(2);
    push(0, mk_blk(0, 7), 1'b1);
    push(3, mk_blk(3, 7), 1'b1);
    wait_drain("t5_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_op_buf_arbiter.md
Name: aes_op_buf_arbiter

Overview:
- Round-robin arbiter/sequencer sharing one aes_encryptor_op_buffer input port between NUM_CORES AES encryption cores, all in the aes_clk domain.
- Grants one core at a time for a burst of up to MAX_BURST cipher blocks.
- Registers each accepted 4x4-byte block into a single output stage that drives the buffer's cipher_txt_vld/cipher_txt_rdy handshake.
- Tags each output block with its source core index.

Parameters:
- NUM_CORES, 4, number of requesting AES cores (2..8)
- MAX_BURST, 4, maximum blocks per grant before forced re-arbitration (1..16)
- NO_ROWS, 4, state rows
- NO_COLS, 4, state columns

Ports:
- aes_clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high reset
- core_txt_vld  input  NUM_CORES  per-core cipher block valid
- core_txt_rdy  output  NUM_CORES  per-core accept (one-hot or zero)
- core_cipher_txt  input  NUM_CORES x NO_ROWS x NO_COLS x 8  per-core cipher block, unpacked [7:0] x[NUM_CORES-1:0][NO_ROWS-1:0][NO_COLS-1:0]
- cipher_txt_vld  output  1  block valid to op buffer
- cipher_txt_rdy  input  1  op buffer accepts block
- p_cipher_txt  output  NO_ROWS x NO_COLS x 8  registered block to op buffer
- cipher_src_id  output  $clog2(NUM_CORES)  source core of p_cipher_txt
- arb_busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset values: cipher_txt_vld=0, p_cipher_txt=0, cipher_src_id=0, core_txt_rdy=0, arb_busy=0, rr_ptr=0, beat_cnt=0, state=IDLE.
- Transfer on a core side: core_txt_vld[i] && core_txt_rdy[i] in the same cycle.
- Transfer on the buffer side: cipher_txt_vld && cipher_txt_rdy in the same cycle.
- FSM states: IDLE, GRANT.
- IDLE:
  - core_txt_rdy=0.
  - If any core_txt_vld is set, select the first requester at or after rr_ptr (ascending, wrap at NUM_CORES-1 -> 0), register grant, clear beat_cnt, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - core_txt_rdy[grant] = (!cipher_txt_vld || cipher_txt_rdy), combinational; all other bits 0.
  - On a core transfer: p_cipher_txt <= core_cipher_txt[grant], cipher_src_id <= grant, cipher_txt_vld <= 1, beat_cnt++.
  - Release to IDLE and set rr_ptr <= (grant+1) mod NUM_CORES when either:
    (a) a core transfer occurs with beat_cnt==MAX_BURST-1, or
    (b) core_txt_vld[grant]==0 in a cycle with no transfer.
- Output stage:
  - cipher_txt_vld clears on a buffer-side transfer unless reloaded in the same cycle.
  - Simultaneous drain and load gives back-to-back blocks at 1 block/cycle.
  - Output data and src_id are held stable while cipher_txt_vld && !cipher_txt_rdy.
- Latency: core_txt_vld rises in IDLE at cycle 0 -> core_txt_rdy at cycle 1 -> cipher_txt_vld at cycle 2.
- Per-burst arbitration bubble: 1 cycle (the IDLE visit).
- Output stage is independent of the FSM:
  - A pending block drains even while the arbiter is in IDLE or re-granting.
  - It is not cleared by burst release.
- Buffer backpressure (cipher_txt_rdy=0 with output full) stalls the granted core; the grant and beat_cnt are held.
- Only the granted core is ever readied; a non-granted core's valid is ignored.
- Fairness: a core waits at most (NUM_CORES-1)*MAX_BURST block transfers plus NUM_CORES bubbles.
- MAX_BURST=1: strict per-block round robin.
- Reset mid-burst: grant, rr_ptr and beat_cnt clear; any held output block is discarded (cipher_txt_vld=0 on the cycle after reset is sampled).

Optional Feature:
- Macro: AES_OP_ARB_STATS_EN.
- When defined, add outputs:
  - blk_cnt: NUM_CORES x 16, per-core accepted-block counters, saturating at 16'hFFFF.
  - stall_cnt: 16, saturating count of cycles with cipher_txt_vld && !cipher_txt_rdy.
- All counters clear on reset.
- When undefined: no counters, ports absent, identical functional behaviour.

Decomposition:
- Package aes_op_arb_pkg:
  - arb_state_e enum {IDLE, GRANT}
  - cipher_blk_t typedef (NO_ROWS x NO_COLS x 8 unpacked)
  - STAT_W=16 constant
- Sub-module rr_pick: combinational first-set-at-or-after-pointer selector, returns index and found flag.

Test Plan:
- Single core: core 2 asserts vld with block 0x00..0x0F, buffer rdy=1 -> core_txt_rdy[2] at cycle 1, cipher_txt_vld at cycle 2 with that block, src_id=2.
- All 4 cores continuously valid, MAX_BURST=4, rdy=1 -> src_id sequence 0,0,0,0,1,1,1,1,2,...,3 with one bubble between bursts; rr_ptr wraps to 0.
- Backpressure: rdy low for 5 cycles mid-burst -> p_cipher_txt and src_id stable, core_txt_rdy low, beat_cnt unchanged; resumes with no lost or duplicate block.
- Early release: core 1 drops vld after 2 blocks -> FSM to IDLE, next grant goes to core 2 (or the next requester after 1).
- Reset asserted while output holds an unaccepted block -> cipher_txt_vld=0, rr_ptr=0, next grant restarts at core 0.
- With AES_OP_ARB_STATS_EN: 10 blocks from core 3 plus 7 stall cycles -> blk_cnt[3]=10, stall_cnt=7; saturation checked by forcing 65536 transfers -> 16'hFFFF.
